// File: rtl/id_stage_pkg.sv
// id_stage_pkg
// Shared constants for the decode stage: MIPS opcode/funct encodings,
// the bubble (NOP) instruction word and instruction field bit positions.
// No ports; imported by if_id_reg and id_stage.
package id_stage_pkg;

   localparam logic [5:0]  OP_RTYPE = 6'b000000;
   localparam logic [5:0]  OP_BEQ   = 6'b000100;
   localparam logic [5:0]  OP_BNE   = 6'b000101;
   localparam logic [5:0]  OP_J     = 6'b000010;
   localparam logic [5:0]  OP_JAL   = 6'b000011;
   localparam logic [5:0]  FUNCT_JR = 6'b001000;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   // Instruction field bit positions
   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int RS_MSB    = 25;
   localparam int RS_LSB    = 21;
   localparam int RT_MSB    = 20;
   localparam int RT_LSB    = 16;
   localparam int RD_MSB    = 15;
   localparam int RD_LSB    = 11;
   localparam int IMM_MSB   = 15;
   localparam int IMM_LSB   = 0;
   localparam int FUNCT_MSB = 5;
   localparam int FUNCT_LSB = 0;
   localparam int TGT_MSB   = 25;
   localparam int TGT_LSB   = 0;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg
// IF/ID pipeline register holding instruction, PC+4 and a valid bit.
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   i_stall         hold all contents (highest priority)
//   i_flush         load a bubble: NOP, valid=0, PC+4 still captured
//   i_instr, i_pc4  fetch-side instruction and PC+4
//   o_instr, o_pc4, o_valid  registered contents
// Control contract: there is no valid/ready handshake; the stage advances
// every edge unless i_stall is high, and i_flush only acts when not stalled.
module if_id_reg
   import id_stage_pkg::*;
#(
   parameter int          WIDTH = 32,
   parameter logic [31:0] NOP   = NOP_WORD
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_stall,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_instr,
   input  logic [WIDTH-1:0] i_pc4,
   output logic [WIDTH-1:0] o_instr,
   output logic [WIDTH-1:0] o_pc4,
   output logic             o_valid
);

   logic [WIDTH-1:0] r_instr;
   logic [WIDTH-1:0] r_pc4;
   logic             r_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr <= WIDTH'(NOP);
         r_pc4   <= '0;
         r_valid <= 1'b0;
      end else if (i_stall) begin
         r_instr <= r_instr;
         r_pc4   <= r_pc4;
         r_valid <= r_valid;
      end else if (i_flush) begin
         // Squash the wrong-path fetch; PC+4 is still tracked so the
         // bubble carries a sensible address.
         r_instr <= WIDTH'(NOP);
         r_pc4   <= i_pc4;
         r_valid <= 1'b0;
      end else begin
         r_instr <= i_instr;
         r_pc4   <= i_pc4;
         r_valid <= 1'b1;
      end
   end

   assign o_instr = r_instr;
   assign o_pc4   = r_pc4;
   assign o_valid = r_valid;

endmodule

// File: rtl/id_stage.sv
// id_stage
// Decode stage: IF/ID register, control-transfer resolution (beq, bne, j,
// jal, jr) with redirect outputs back to fetch, and a taken-redirect counter.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   stall                     hazard stall (shared with the fetch PC register)
//   instructionF, PCPlus4F    fetch-side instruction / PC+4
//   RD1, RD2, ALUOutM         register operands and MEM forwarding value
//   ForwardAD, ForwardBD      operand forwarding selects
//   instructionD, PCPlus4D, ValidD  registered IF/ID contents
//   rsD, rtD, rdD, SignImmD   decoded fields
//   PCSrcD, PCBranchD, JumpD, JalD, JrD, JumpAddr  redirect to fetch
//   RedirectCnt               number of taken redirects (wraps)
// Target formation assumes a 32-bit instruction word (WIDTH = 32).
module id_stage
   import id_stage_pkg::*;
#(
   parameter int          WIDTH = 32,
   parameter logic [31:0] NOP   = NOP_WORD,
   parameter int          CNT_W = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic [WIDTH-1:0] instructionF,
   input  logic [WIDTH-1:0] PCPlus4F,
   input  logic [WIDTH-1:0] RD1,
   input  logic [WIDTH-1:0] RD2,
   input  logic [WIDTH-1:0] ALUOutM,
   input  logic             ForwardAD,
   input  logic             ForwardBD,
   output logic [WIDTH-1:0] instructionD,
   output logic [WIDTH-1:0] PCPlus4D,
   output logic             ValidD,
   output logic [4:0]       rsD,
   output logic [4:0]       rtD,
   output logic [4:0]       rdD,
   output logic [WIDTH-1:0] SignImmD,
   output logic             PCSrcD,
   output logic [WIDTH-1:0] PCBranchD,
   output logic             JumpD,
   output logic             JalD,
   output logic             JrD,
   output logic [WIDTH-1:0] JumpAddr,
   output logic [CNT_W-1:0] RedirectCnt
);

   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [5:0]       w_opcode;
   logic [5:0]       w_funct;
   logic             w_redirect;
   logic [CNT_W-1:0] r_cnt;

   if_id_reg #(
      .WIDTH (WIDTH),
      .NOP   (NOP)
   ) u_if_id_reg (
      .clk     (clk),
      .rst_n   (rst),
      .i_stall (stall),
      .i_flush (w_redirect),
      .i_instr (instructionF),
      .i_pc4   (PCPlus4F),
      .o_instr (instructionD),
      .o_pc4   (PCPlus4D),
      .o_valid (ValidD)
   );

   assign w_a = ForwardAD ? ALUOutM : RD1;
   assign w_b = ForwardBD ? ALUOutM : RD2;

   assign w_opcode = instructionD[OP_MSB:OP_LSB];
   assign w_funct  = instructionD[FUNCT_MSB:FUNCT_LSB];
   assign rsD      = instructionD[RS_MSB:RS_LSB];
   assign rtD      = instructionD[RT_MSB:RT_LSB];
   assign rdD      = instructionD[RD_MSB:RD_LSB];
   assign SignImmD = {{(WIDTH-16){instructionD[IMM_MSB]}}, instructionD[IMM_MSB:IMM_LSB]};

   // All redirect outputs are forced to 0 for a bubble so that a flushed
   // slot can never redirect again on the following cycle.
   always_comb begin
      PCSrcD    = 1'b0;
      JumpD     = 1'b0;
      JalD      = 1'b0;
      JrD       = 1'b0;
      JumpAddr  = '0;
      PCBranchD = '0;
      if (ValidD) begin
         PCBranchD = PCPlus4D + (SignImmD << 2);
         case (w_opcode)
            OP_BEQ:   PCSrcD = (w_a == w_b);
            OP_BNE:   PCSrcD = (w_a != w_b);
            OP_J: begin
               JumpD    = 1'b1;
               JumpAddr = {PCPlus4D[WIDTH-1:28], instructionD[TGT_MSB:TGT_LSB], 2'b00};
            end
            OP_JAL: begin
               JalD     = 1'b1;
               JumpAddr = {PCPlus4D[WIDTH-1:28], instructionD[TGT_MSB:TGT_LSB], 2'b00};
            end
            OP_RTYPE: begin
               if (w_funct == FUNCT_JR) begin
                  JrD      = 1'b1;
                  JumpAddr = w_a;
               end
            end
            default: ;
         endcase
      end
   end

   assign w_redirect = PCSrcD | JumpD | JalD | JrD;

   // A stalled redirect is not counted; it re-evaluates once the stall drops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (!stall && w_redirect) begin
         r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign RedirectCnt = r_cnt;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  localparam logic [31:0] ALU_INS = 32'h0022_1820; // add $3,$1,$2

  logic        clk;
  logic        rst;
  logic        stall;
  logic [31:0] instructionF, PCPlus4F, RD1, RD2, ALUOutM;
  logic        ForwardAD, ForwardBD;

  logic [31:0] instructionD, PCPlus4D, SignImmD, PCBranchD, JumpAddr, RedirectCnt;
  logic        ValidD, PCSrcD, JumpD, JalD, JrD;
  logic [4:0]  rsD, rtD, rdD;

  logic [31:0] instructionD4, PCPlus4D4, SignImmD4, PCBranchD4, JumpAddr4;
  logic        ValidD4, PCSrcD4, JumpD4, JalD4, JrD4;
  logic [4:0]  rsD4, rtD4, rdD4;
  logic [3:0]  RedirectCnt4;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_cnt;

  id_stage #(.WIDTH(32), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .instructionF(instructionF), .PCPlus4F(PCPlus4F),
    .RD1(RD1), .RD2(RD2), .ALUOutM(ALUOutM), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .instructionD(instructionD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .rsD(rsD), .rtD(rtD),
    .rdD(rdD), .SignImmD(SignImmD), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .JumpD(JumpD),
    .JalD(JalD), .JrD(JrD), .JumpAddr(JumpAddr), .RedirectCnt(RedirectCnt)
  );

  id_stage #(.WIDTH(32), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .stall(stall), .instructionF(instructionF), .PCPlus4F(PCPlus4F),
    .RD1(RD1), .RD2(RD2), .ALUOutM(ALUOutM), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .instructionD(instructionD4), .PCPlus4D(PCPlus4D4), .ValidD(ValidD4), .rsD(rsD4), .rtD(rtD4),
    .rdD(rdD4), .SignImmD(SignImmD4), .PCSrcD(PCSrcD4), .PCBranchD(PCBranchD4), .JumpD(JumpD4),
    .JalD(JalD4), .JrD(JrD4), .JumpAddr(JumpAddr4), .RedirectCnt(RedirectCnt4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic load(input logic [31:0] ins, input logic [31:0] pc4);
    @(negedge clk);
    instructionF = ins;
    PCPlus4F     = pc4;
    stall        = 1'b0;
    @(posedge clk);
    #1;
    instructionF = ALU_INS;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // tests
  task automatic test_reset();
    #1;
    n_checks++; if (ValidD !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0h expected 0", ValidD); end
    n_checks++; if (instructionD !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %0h expected 0", instructionD); end
    n_checks++; if (PCPlus4D !== 32'h0) begin n_fail++; $display("FAIL rst_pc4: got %0h expected 0", PCPlus4D); end
    n_checks++; if (RedirectCnt !== 32'h0) begin n_fail++; $display("FAIL rst_cnt: got %0h expected 0", RedirectCnt); end
    n_checks++; if ({PCSrcD, JumpD, JalD, JrD} !== 4'h0) begin n_fail++; $display("FAIL rst_redirect: got %0h expected 0", {PCSrcD, JumpD, JalD, JrD}); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_beq_fwd();
    load(32'h1022_FFFE, 32'h0000_0100);
    RD1 = 32'd5; RD2 = 32'd7; ALUOutM = 32'd7; ForwardAD = 1'b1; ForwardBD = 1'b0;
    #1;
    n_checks++; if (PCSrcD !== 1'b1) begin n_fail++; $display("FAIL beq_pcsrc: got %0h expected 1", PCSrcD); end
    n_checks++; if (PCBranchD !== 32'h0000_00F8) begin n_fail++; $display("FAIL beq_target: got %0h expected f8", PCBranchD); end
    n_checks++; if (SignImmD !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL beq_signimm: got %0h expected fffffffe", SignImmD); end
    n_checks++; if ({rsD, rtD} !== {5'd1, 5'd2}) begin n_fail++; $display("FAIL beq_fields: got %0h expected %0h", {rsD, rtD}, {5'd1, 5'd2}); end
    ForwardAD = 1'b0; // A = RD1 = 5, differs from B
    #1;
    n_checks++; if (PCSrcD !== 1'b0) begin n_fail++; $display("FAIL beq_nofwd: got %0h expected 0", PCSrcD); end
    ForwardAD = 1'b1;
    @(negedge clk);
    PCPlus4F = 32'h0000_0104;
    step();
    exp_cnt = exp_cnt + 1;
    n_checks++; if (ValidD !== 1'b0) begin n_fail++; $display("FAIL beq_flush_valid: got %0h expected 0", ValidD); end
    n_checks++; if (instructionD !== 32'h0) begin n_fail++; $display("FAIL beq_flush_instr: got %0h expected 0", instructionD); end
    n_checks++; if (PCPlus4D !== 32'h0000_0104) begin n_fail++; $display("FAIL beq_flush_pc4: got %0h expected 104", PCPlus4D); end
    n_checks++; if (RedirectCnt !== exp_cnt) begin n_fail++; $display("FAIL beq_cnt: got %0h expected %0h", RedirectCnt, exp_cnt); end
    n_checks++; if (PCSrcD !== 1'b0) begin n_fail++; $display("FAIL bubble_pcsrc: got %0h expected 0", PCSrcD); end
  endtask

  task automatic test_bne();
    load(32'h1422_FFFE, 32'h0000_0200);
    RD1 = 32'd7; RD2 = 32'd7; ForwardAD = 1'b0; ForwardBD = 1'b0;
    #1;
    n_checks++; if (PCSrcD !== 1'b0) begin n_fail++; $display("FAIL bne_eq_pcsrc: got %0h expected 0", PCSrcD); end
    RD2 = 32'd8;
    #1;
    n_checks++; if (PCSrcD !== 1'b1) begin n_fail++; $display("FAIL bne_ne_pcsrc: got %0h expected 1", PCSrcD); end
    RD2 = 32'd7;
    step();
    n_checks++; if (ValidD !== 1'b1) begin n_fail++; $display("FAIL bne_noflush_valid: got %0h expected 1", ValidD); end
    n_checks++; if (instructionD !== ALU_INS) begin n_fail++; $display("FAIL bne_noflush_instr: got %0h expected %0h", instructionD, ALU_INS); end
    n_checks++; if (RedirectCnt !== exp_cnt) begin n_fail++; $display("FAIL bne_cnt: got %0h expected %0h", RedirectCnt, exp_cnt); end
  endtask

  task automatic test_jumps();
    load(32'h0C00_0040, 32'h8000_0010);
    #1;
    n_checks++; if ({JalD, JumpD, JrD, PCSrcD} !== 4'b1000) begin n_fail++; $display("FAIL jal_flags: got %0b expected 1000", {JalD, JumpD, JrD, PCSrcD}); end
    n_checks++; if (JumpAddr !== 32'h8000_0100) begin n_fail++; $display("FAIL jal_addr: got %0h expected 80000100", JumpAddr); end
    step();
    exp_cnt = exp_cnt + 1;
    n_checks++; if (RedirectCnt !== exp_cnt) begin n_fail++; $display("FAIL jal_cnt: got %0h expected %0h", RedirectCnt, exp_cnt); end

    load(32'h0020_0008, 32'h0000_0300);
    RD1 = 32'h0040_0020; ForwardAD = 1'b0;
    #1;
    n_checks++; if ({JalD, JumpD, JrD, PCSrcD} !== 4'b0010) begin n_fail++; $display("FAIL jr_flags: got %0b expected 0010", {JalD, JumpD, JrD, PCSrcD}); end
    n_checks++; if (JumpAddr !== 32'h0040_0020) begin n_fail++; $display("FAIL jr_addr: got %0h expected 400020", JumpAddr); end
    step();
    exp_cnt = exp_cnt + 1;
    n_checks++; if (ValidD !== 1'b0) begin n_fail++; $display("FAIL jr_flush_valid: got %0h expected 0", ValidD); end

    load(32'h0800_0010, 32'h0000_1004);
    #1;
    n_checks++; if ({JalD, JumpD, JrD, PCSrcD} !== 4'b0100) begin n_fail++; $display("FAIL j_flags: got %0b expected 0100", {JalD, JumpD, JrD, PCSrcD}); end
    n_checks++; if (JumpAddr !== 32'h0000_0040) begin n_fail++; $display("FAIL j_addr: got %0h expected 40", JumpAddr); end
    step();
    exp_cnt = exp_cnt + 1;
    n_checks++; if (RedirectCnt !== exp_cnt) begin n_fail++; $display("FAIL j_cnt: got %0h expected %0h", RedirectCnt, exp_cnt); end
  endtask

  task automatic test_stall();
    load(32'h1022_0004, 32'h0000_0400);
    RD1 = 32'd9; RD2 = 32'd9; ForwardAD = 1'b0; ForwardBD = 1'b0;
    #1;
    n_checks++; if (PCSrcD !== 1'b1) begin n_fail++; $display("FAIL stall_pcsrc: got %0h expected 1", PCSrcD); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall = 1'b1;
      instructionF = 32'h0022_2020;
      step();
      n_checks++; if (instructionD !== 32'h1022_0004) begin n_fail++; $display("FAIL stall_hold_instr: got %0h expected 10220004", instructionD); end
      n_checks++; if (ValidD !== 1'b1) begin n_fail++; $display("FAIL stall_hold_valid: got %0h expected 1", ValidD); end
      n_checks++; if (RedirectCnt !== exp_cnt) begin n_fail++; $display("FAIL stall_hold_cnt: got %0h expected %0h", RedirectCnt, exp_cnt); end
    end
    @(negedge clk);
    stall = 1'b0;
    step();
    exp_cnt = exp_cnt + 1;
    n_checks++; if ({ValidD, instructionD} !== 33'h0) begin n_fail++; $display("FAIL stall_release_flush: got %0h expected 0", {ValidD, instructionD}); end
    n_checks++; if (RedirectCnt !== exp_cnt) begin n_fail++; $display("FAIL stall_release_cnt: got %0h expected %0h", RedirectCnt, exp_cnt); end
  endtask

  task automatic test_wrap();
    load(32'h1022_0001, 32'hFFFF_FFFC);
    RD1 = 32'd1; RD2 = 32'd2;
    #1;
    n_checks++; if (PCBranchD !== 32'h0) begin n_fail++; $display("FAIL wrap_target: got %0h expected 0", PCBranchD); end
    n_checks++; if (PCSrcD !== 1'b0) begin n_fail++; $display("FAIL wrap_pcsrc: got %0h expected 0", PCSrcD); end
  endtask

  task automatic test_reset_mid();
    load(32'h1022_0004, 32'h0000_0500);
    RD1 = 32'd3; RD2 = 32'd3;
    stall = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    exp_cnt = 32'h0;
    n_checks++; if (ValidD !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0h expected 0", ValidD); end
    n_checks++; if (PCSrcD !== 1'b0) begin n_fail++; $display("FAIL midrst_pcsrc: got %0h expected 0", PCSrcD); end
    n_checks++; if (instructionD !== 32'h0) begin n_fail++; $display("FAIL midrst_instr: got %0h expected 0", instructionD); end
    n_checks++; if (RedirectCnt !== 32'h0) begin n_fail++; $display("FAIL midrst_cnt: got %0h expected 0", RedirectCnt); end
    @(negedge clk);
    rst = 1'b1;
    stall = 1'b0;
    instructionF = 32'h0022_4820;
    step();
    n_checks++; if (instructionD !== 32'h0022_4820) begin n_fail++; $display("FAIL midrst_first_instr: got %0h expected 224820", instructionD); end
    n_checks++; if (ValidD !== 1'b1) begin n_fail++; $display("FAIL midrst_first_valid: got %0h expected 1", ValidD); end
  endtask

  task automatic test_straight();
    logic [31:0] ins;
    for (int i = 0; i < 10; i++) begin
      ins = ALU_INS | (32'(i) << 6);
      @(negedge clk);
      instructionF = ins;
      PCPlus4F = 32'h0000_1000 + 32'(4 * i);
      step();
      n_checks++; if (instructionD !== ins) begin n_fail++; $display("FAIL straight_instr: got %0h expected %0h", instructionD, ins); end
      n_checks++; if (PCPlus4D !== 32'h0000_1000 + 32'(4 * i)) begin n_fail++; $display("FAIL straight_pc4: got %0h expected %0h", PCPlus4D, 32'h0000_1000 + 32'(4 * i)); end
      n_checks++; if (ValidD !== 1'b1) begin n_fail++; $display("FAIL straight_valid: got %0h expected 1", ValidD); end
      n_checks++; if ({PCSrcD, JumpD, JalD, JrD} !== 4'h0) begin n_fail++; $display("FAIL straight_redirect: got %0h expected 0", {PCSrcD, JumpD, JalD, JrD}); end
    end
    n_checks++; if (rdD !== 5'd3) begin n_fail++; $display("FAIL straight_rd: got %0h expected 3", rdD); end
  endtask

  task automatic do_jump();
    load(32'h0800_0010, 32'h0000_1004);
    step();
    exp_cnt = exp_cnt + 1;
  endtask

  task automatic test_counter_wrap();
    for (int i = 0; i < 16; i++) begin
      if (exp_cnt[3:0] == 4'hF) break;
      do_jump();
    end
    n_checks++; if (RedirectCnt4 !== 4'hF) begin n_fail++; $display("FAIL cnt4_allones: got %0h expected f", RedirectCnt4); end
    do_jump();
    n_checks++; if (RedirectCnt4 !== 4'h0) begin n_fail++; $display("FAIL cnt4_wrap: got %0h expected 0", RedirectCnt4); end
    n_checks++; if (RedirectCnt !== exp_cnt) begin n_fail++; $display("FAIL cnt32_after_wrap: got %0h expected %0h", RedirectCnt, exp_cnt); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    exp_cnt = 32'h0;
    rst = 1'b0;
    stall = 1'b0;
    instructionF = ALU_INS;
    PCPlus4F = 32'h0;
    RD1 = 32'h0; RD2 = 32'h0; ALUOutM = 32'h0;
    ForwardAD = 1'b0; ForwardBD = 1'b0;
    #12;
    test_reset();
    test_beq_fwd();
    test_bne();
    test_jumps();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_straight();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode-side neighbour of the fetch stage. Holds the IF/ID pipeline register (instruction, PC+4, valid bit) with stall hold and flush-to-bubble.
- Resolves control transfer in ID (beq, bne, j, jal, jr) and drives redirect signals straight back to fetch: PCSrcD, PCBranchD, JumpD, JalD, JrD, JumpAddr.
- No branch delay slot: the wrong-path instruction fetched behind a taken transfer is squashed.

Parameters:
- WIDTH, 32, data/address width.
- NOP, 32'h00000000, instruction word loaded on flush or reset.
- CNT_W, 32, width of the taken-redirect counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- stall  input  1  hazard stall; same signal that freezes the fetch PC register.
- instructionF  input  WIDTH  fetched instruction.
- PCPlus4F  input  WIDTH  fetch PC+4.
- RD1, RD2  input  WIDTH  register-file read data for rs, rt.
- ALUOutM  input  WIDTH  MEM-stage result, used for forwarding.
- ForwardAD, ForwardBD  input  1  select ALUOutM instead of RD1 / RD2.
- instructionD  output  WIDTH  registered instruction.
- PCPlus4D  output  WIDTH  registered PC+4.
- ValidD  output  1  ID slot holds a real instruction.
- rsD, rtD, rdD  output  5  register fields [25:21], [20:16], [15:11].
- SignImmD  output  WIDTH  sign-extended [15:0].
- PCSrcD  output  1  taken beq/bne.
- PCBranchD  output  WIDTH  branch target.
- JumpD, JalD, JrD  output  1  j / jal / jr decoded.
- JumpAddr  output  WIDTH  jump target.
- RedirectCnt  output  CNT_W  count of taken redirects.

Behaviour:
- Reset (rst=0, asynchronous):
  - instructionD=NOP, PCPlus4D=0, ValidD=0, RedirectCnt=0.
  - All redirect outputs are 0 while ValidD=0.
  - Applies mid-operation at any time, independent of clk.
- Operands:
  - A = ForwardAD ? ALUOutM : RD1.
  - B = ForwardBD ? ALUOutM : RD2.
- Decode (combinational from instructionD, every output gated by ValidD):
  - beq (op 000100): PCSrcD = (A==B).
  - bne (op 000101): PCSrcD = (A!=B).
  - j (op 000010): JumpD=1.
  - jal (op 000011): JalD=1.
  - jr (op 000000, funct 001000): JrD=1.
- Targets:
  - PCBranchD = PCPlus4D + (SignImmD<<2), modulo 2^WIDTH (wrap-around, no overflow flag).
  - JumpAddr: for jr, JumpAddr=A. For j/jal, JumpAddr={PCPlus4D[31:28], instructionD[25:0], 2'b00}. Otherwise 0.
- Redirect: redirect = PCSrcD|JumpD|JalD|JrD.
- Register update on each rising edge, priority order:
  1. stall=1: hold instructionD, PCPlus4D, ValidD. No flush and no counter increment, even if redirect=1; the transfer re-evaluates the next cycle.
  2. stall=0 and redirect=1: flush. instructionD<=NOP, ValidD<=0, PCPlus4D<=PCPlus4F. RedirectCnt increments by 1.
  3. Otherwise: instructionD<=instructionF, PCPlus4D<=PCPlus4F, ValidD<=1.
- Latency:
  - IF to ID: 1 cycle.
  - Redirect outputs are combinational in the same cycle as decode. Fetch latches the target at the same edge the flush occurs.
  - Taken-transfer penalty: exactly 1 bubble.
- Back-to-back: the instruction after a flush is a bubble, so a redirect can never fire on two consecutive cycles.
- RedirectCnt wraps from all-ones to 0.
- Unrecognised opcodes: all redirect outputs 0, and the instruction passes through.

Decomposition:
- Shared package:
  - Opcode constants: OP_RTYPE, OP_BEQ, OP_BNE, OP_J, OP_JAL, FUNCT_JR.
  - NOP word.
  - Instruction field bit positions.
- One sub-module, if_id_reg: the stall/flush pipeline register (instruction, PC+4, valid).
- Branch decode, target arithmetic and the counter stay in id_stage.

Test Plan:
- Reset:
  - Stimulus: assert rst=0 mid-stream with instructionD=beq holding taken operands.
  - Required response: immediately ValidD=0, PCSrcD=0, instructionD=0, RedirectCnt=0. After release, the first edge loads instructionF with ValidD=1.
- beq taken with forwarding:
  - Stimulus: PCPlus4D=0x100, imm=0xFFFE, RD1=5, ALUOutM=7, RD2=7, ForwardAD=1.
  - Required response: PCSrcD=1, PCBranchD=0xF8. The next edge gives ValidD=0, instructionD=NOP and RedirectCnt=1.
  - Repeat with bne and A=B: required response is PCSrcD=0 and no flush.
- jal and jr:
  - jal stimulus: instructionD=0x0C000040 at PCPlus4D=0x80000010. Required response: JalD=1, JumpAddr=0x80000100.
  - jr stimulus: rs operand RD1=0x00400020. Required response: JrD=1, JumpAddr=0x00400020.
- Stall with pending branch:
  - Stimulus: stall=1 for 3 cycles while a taken beq sits in ID.
  - Required response: instructionD, ValidD and RedirectCnt all unchanged. Flush happens only at the first edge with stall=0.
- Wrap-around:
  - Stimulus: PCPlus4D=0xFFFFFFFC, imm=0x0001.
  - Required response: PCBranchD=0x00000000.
  - Counter: preload to all-ones via a CNT_W=4 instance, then take a redirect. Required response: RedirectCnt=0.
- Straight-line stream:
  - Stimulus: 10 sequential ALU instructions with stall=0.
  - Required response: each appears on instructionD exactly 1 cycle after instructionF, ValidD=1 throughout, no redirect asserted.
